// File: rtl/bcd_msg_loader_pkg.sv
// Shared types and constants for the BCD message loader: state encoding,
// message geometry and the debounce-length calculation.
package bcd_msg_loader_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int BCD_MAX = 9;
    localparam int MSG_W   = 32;
    localparam int DIGIT_W = 4;

    function automatic int db_cycles(input int clk_hz, input int debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

endpackage

// File: rtl/bcd_msg_loader_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-time debouncer and
// a one-cycle press strobe on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DB_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CNT_W = (DB_CYC < 1) ? 1 : $clog2(DB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_prev_q;
    logic             armed_q;
    logic             press_q;
    logic             btn_s;

    assign btn_s   = sync_q[1];
    assign press_o = press_q;

    // After reset the button must be seen released for DB_CYC cycles before
    // presses are honoured, so a button held through reset cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            if (!armed_q) begin
                if (btn_s) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    armed_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (btn_s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= btn_s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_msg_loader.sv
// Captures an 8-digit BCD message from switches and buttons into a packed
// 32-bit word, newest digit in the low nibble; flags a full message.
module bcd_msg_loader
    import bcd_msg_loader_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int NUM_DIGITS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       sw_digit,
    input  logic             btn_enter,
    input  logic             btn_back,
    input  logic             btn_clear,
    output logic [MSG_W-1:0] msg_array,
    output logic [3:0]       digit_count,
    output logic             msg_valid,
    output logic             load_pulse,
    output logic             digit_err
);
    localparam int DB_CYC = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam logic [3:0] FULL_CNT = 4'(NUM_DIGITS);

    // Index 0 = enter, 1 = back, 2 = clear
    logic [2:0]         btn_raw;
    logic [2:0]         press_w;
    logic [DIGIT_W-1:0] sw_sync1_q;
    logic [DIGIT_W-1:0] sw_sync2_q;
    state_e             state_q;
    logic [MSG_W-1:0]   msg_q;
    logic [3:0]         count_q;
    logic               valid_q;
    logic               load_q;
    logic               err_q;

    assign btn_raw = {btn_clear, btn_back, btn_enter};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(.DB_CYC(DB_CYC)) u_db (
                .clk     (clk),
                .rst_n   (rst_n),
                .btn_i   (btn_raw[gi]),
                .press_o (press_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= sw_digit;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Strobe priority: clear over back over enter; losers are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            msg_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            if (press_w[2]) begin
                state_q <= ST_EMPTY;
                msg_q   <= '0;
                count_q <= '0;
                valid_q <= 1'b0;
            end else if (press_w[1]) begin
                if (state_q != ST_EMPTY) begin
                    msg_q   <= {{DIGIT_W{1'b0}}, msg_q[MSG_W-1:DIGIT_W]};
                    count_q <= count_q - 4'd1;
                    valid_q <= 1'b0;
                    state_q <= (count_q == 4'd1) ? ST_EMPTY : ST_ENTRY;
                end
            end else if (press_w[0]) begin
                if (sw_sync2_q > DIGIT_W'(BCD_MAX)) begin
                    err_q <= 1'b1;
                end else if (state_q != ST_FULL) begin
                    msg_q   <= {msg_q[MSG_W-DIGIT_W-1:0], sw_sync2_q};
                    count_q <= count_q + 4'd1;
                    if (count_q == FULL_CNT - 4'd1) begin
                        state_q <= ST_FULL;
                        valid_q <= 1'b1;
                        load_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ENTRY;
                    end
                end
            end
        end
    end

    assign msg_array   = msg_q;
    assign digit_count = count_q;
    assign msg_valid   = valid_q;
    assign load_pulse  = load_q;
    assign digit_err   = err_q;

endmodule

// File: tb/tb_bcd_msg_loader.sv
// Scoreboard bench for bcd_msg_loader with a short debounce time.
module tb_bcd_msg_loader;
    localparam int CLK_HZ      = 8000;
    localparam int DEBOUNCE_MS = 1;
    localparam int DB_CYC      = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int HOLD        = DB_CYC + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw_digit;
    logic        btn_enter, btn_back, btn_clear;
    logic [31:0] msg_array;
    logic [3:0]  digit_count;
    logic        msg_valid, load_pulse, digit_err;

    bcd_msg_loader #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .NUM_DIGITS  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_digit    (sw_digit),
        .btn_enter   (btn_enter),
        .btn_back    (btn_back),
        .btn_clear   (btn_clear),
        .msg_array   (msg_array),
        .digit_count (digit_count),
        .msg_valid   (msg_valid),
        .load_pulse  (load_pulse),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] msg;
        logic [3:0]  cnt;
        logic        valid;
        int          loads;
        int          errs;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          load_seen = 0;
    int          err_seen = 0;
    logic [31:0] m_msg = '0;
    logic [3:0]  m_cnt = '0;

    // Cumulative high-cycle counts; a two-cycle pulse shows up as 2.
    always @(negedge clk) begin
        if (load_pulse === 1'b1) load_seen++;
        if (digit_err === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_msg"}, msg_array, 32'h0);
        chk({tag, "_cnt"}, {28'h0, digit_count}, 32'h0);
        chk({tag, "_valid"}, {31'h0, msg_valid}, 32'h0);
        chk({tag, "_load"}, {31'h0, load_pulse}, 32'h0);
        chk({tag, "_err"}, {31'h0, digit_err}, 32'h0);
    endtask

    // b[0]=enter, b[1]=back, b[2]=clear
    task automatic model_push(input logic [2:0] b, input logic [3:0] d);
        exp_t e;
        e.loads = 0;
        e.errs  = 0;
        if (b[2]) begin
            m_msg = '0;
            m_cnt = '0;
        end else if (b[1]) begin
            if (m_cnt != 0) begin
                m_msg = m_msg >> 4;
                m_cnt = m_cnt - 1;
            end
        end else if (b[0]) begin
            if (d > 9) begin
                e.errs = 1;
            end else if (m_cnt < 8) begin
                m_msg = {m_msg[27:0], d};
                m_cnt = m_cnt + 1;
                if (m_cnt == 8) e.loads = 1;
            end
        end
        e.msg   = m_msg;
        e.cnt   = m_cnt;
        e.valid = (m_cnt == 8);
        sb_q.push_back(e);
    endtask

    task automatic press(input logic [2:0] b, input logic [3:0] d);
        exp_t e;
        int   l0, e0;
        sw_digit = d;
        repeat (4) @(negedge clk);
        model_push(b, d);
        l0 = load_seen;
        e0 = err_seen;
        {btn_clear, btn_back, btn_enter} = b;
        repeat (HOLD) @(negedge clk);
        {btn_clear, btn_back, btn_enter} = 3'b000;
        repeat (HOLD) @(negedge clk);
        e = sb_q.pop_front();
        chk("msg", msg_array, e.msg);
        chk("cnt", {28'h0, digit_count}, {28'h0, e.cnt});
        chk("valid", {31'h0, msg_valid}, {31'h0, e.valid});
        chk("load_pulses", load_seen - l0, e.loads);
        chk("err_pulses", err_seen - e0, e.errs);
        $display("txn btn=%b d=%h msg=%h cnt=%0d valid=%b", b, d, msg_array, digit_count, msg_valid);
    endtask

    task automatic bounce_enter(input logic [3:0] d);
        sw_digit = d;
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1;
            repeat (3) @(negedge clk);
            btn_enter = 1'b0;
            repeat (3) @(negedge clk);
        end
        press(3'b001, d);
    endtask

    initial begin
        int digs[8] = '{4, 2, 0, 2, 4, 1, 3, 7};
        rst_n = 1'b0;
        sw_digit = '0;
        btn_enter = 1'b0;
        btn_back = 1'b0;
        btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (DB_CYC + 6) @(negedge clk);

        for (int i = 0; i < 8; i++) press(3'b001, 4'(digs[i]));
        chk("full_msg", msg_array, 32'h42024137);
        chk("full_cnt", {28'h0, digit_count}, 32'd8);
        chk("full_valid", {31'h0, msg_valid}, 32'd1);

        press(3'b010, 4'd0);
        chk("back_msg", msg_array, 32'h04202413);
        chk("back_cnt", {28'h0, digit_count}, 32'd7);
        chk("back_valid", {31'h0, msg_valid}, 32'd0);
        press(3'b001, 4'd7);
        chk("refill_msg", msg_array, 32'h42024137);

        press(3'b001, 4'd5);
        chk("full_ignore_msg", msg_array, 32'h42024137);
        chk("full_ignore_cnt", {28'h0, digit_count}, 32'd8);

        press(3'b100, 4'd0);
        bounce_enter(4'd3);
        chk("bounce_msg", msg_array, 32'h00000003);
        chk("bounce_cnt", {28'h0, digit_count}, 32'd1);

        press(3'b001, 4'hA);
        chk("bad_digit_msg", msg_array, 32'h00000003);
        press(3'b100, 4'd0);
        press(3'b010, 4'd0);
        chk("empty_back_cnt", {28'h0, digit_count}, 32'd0);

        press(3'b001, 4'd1);
        press(3'b001, 4'd2);
        press(3'b001, 4'd3);
        press(3'b101, 4'd4);
        chk("clear_wins_msg", msg_array, 32'h0);
        chk("clear_wins_cnt", {28'h0, digit_count}, 32'd0);

        press(3'b001, 4'd5);
        press(3'b001, 4'd6);
        sw_digit = 4'd8;
        repeat (4) @(negedge clk);
        btn_enter = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        m_msg = '0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * DB_CYC) @(negedge clk);
        chk("held_msg", msg_array, 32'h0);
        chk("held_cnt", {28'h0, digit_count}, 32'd0);
        btn_enter = 1'b0;
        repeat (HOLD) @(negedge clk);
        press(3'b001, 4'd8);
        chk("repress_msg", msg_array, 32'h00000008);
        chk("repress_cnt", {28'h0, digit_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
